// File: rtl/soc_system_hps_write_ctrl.sv
// HPS output PIO: DATA level register with set/clear aliases and a shared-timer strobe generator (SOC_SYSTEM_HPS_WRITE_CTRL_PULSE_EN).
// Latency: writes land on the accepting edge; readdata is registered one cycle after address.
// Backpressure: none, every access completes in a single cycle.
module soc_system_hps_write_ctrl #(
  parameter int                    DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    CNT_WIDTH       = 16,
  parameter int                    PULSE_LEN_RESET = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] pulse_out
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [31:0]           rd_mux;
  logic                  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        3'd0:    out_port <= wd_data;
        3'd4:    out_port <= out_port | wd_data;
        3'd5:    out_port <= out_port & ~wd_data;
        default: out_port <= out_port;
      endcase
    end
  end

`ifdef SOC_SYSTEM_HPS_WRITE_CTRL_PULSE_EN
  logic [CNT_WIDTH-1:0] pulse_len;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] len_eff;
  logic                 busy;
  logic                 expiring;
  logic [31:0]          status;

  assign len_eff  = (pulse_len == '0) ? CNT_WIDTH'(1) : pulse_len;
  assign busy     = |counter;
  assign expiring = (counter == CNT_WIDTH'(1));
  assign status   = 32'({32'(counter), 16'b0}) | {31'b0, busy};

  // A PULSE write on the expiry edge replaces the expiring bits instead of extending them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len <= CNT_WIDTH'(PULSE_LEN_RESET);
      counter   <= '0;
      pulse_out <= '0;
    end else begin
      if (wr_en && address == 3'd3) begin
        pulse_len <= writedata[CNT_WIDTH-1:0];
      end
      if (wr_en && address == 3'd2) begin
        counter   <= len_eff;
        pulse_out <= expiring ? wd_data : (pulse_out | wd_data);
      end else if (busy) begin
        counter <= counter - CNT_WIDTH'(1);
        if (expiring) begin
          pulse_out <= '0;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = 32'(out_port);
      3'd2:    rd_mux = 32'(pulse_out);
      3'd3:    rd_mux = 32'(pulse_len);
      3'd6:    rd_mux = status;
      default: rd_mux = '0;
    endcase
  end
`else
  assign pulse_out = '0;

  always_comb begin
    rd_mux = '0;
    if (address == 3'd0) begin
      rd_mux = 32'(out_port);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_hps_write_ctrl.sv
// Scoreboard bench for soc_system_hps_write_ctrl: expectations queued with each stimulus, checked after the next edge.
module tb_soc_system_hps_write_ctrl;

`ifdef SOC_SYSTEM_HPS_WRITE_CTRL_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_PUL = 2;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic [7:0]  pulse_out;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  soc_system_hps_write_ctrl #(
    .DATA_WIDTH     (8),
    .RESET_VALUE    (8'hA5),
    .CNT_WIDTH      (16),
    .PULSE_LEN_RESET(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .pulse_out (pulse_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pe(input logic [31:0] v);
    return PEN ? v : 32'h0;
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_RD:    chk(e.tag, readdata, e.val);
        K_OUT:   chk(e.tag, 32'(out_port), e.val);
        default: chk(e.tag, 32'(pulse_out), e.val);
      endcase
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
  endtask

  task automatic rd(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
  endtask

  logic [31:0] pul3[4];
  logic [31:0] st3[4];

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    pul3 = '{32'h81, 32'h81, 32'h00, 32'h00};
    st3  = '{32'h0003_0001, 32'h0002_0001, 32'h0001_0001, 32'h0};

    // reset state
    #12;
    chk("rst_out_port", 32'(out_port), 32'hA5);
    chk("rst_pulse_out", 32'(pulse_out), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    rd(3'd3); push("rst_pulse_len", K_RD, pe(32'd4)); step();

    // level register and set/clear aliases
    wr(3'd0, 32'hFFFF_FF3C); push("data_wr", K_OUT, 32'h3C); step();
    wr(3'd4, 32'h0000_0001); push("outset", K_OUT, 32'h3D); step();
    wr(3'd5, 32'h0000_000C); push("outclear", K_OUT, 32'h31); step();
    rd(3'd0); push("rd_data", K_RD, 32'h31); step();
    rd(3'd4); push("rd_outset_zero", K_RD, 32'h0); step();
    wr(3'd1, 32'hFFFF_FFFF); step();
    rd(3'd1); push("rd_reserved", K_RD, 32'h0); push("reserved_no_effect", K_OUT, 32'h31); step();

    // single 3-cycle pulse with STATUS countdown
    wr(3'd3, 32'd3); step();
    wr(3'd2, 32'h81); push("p3_start", K_PUL, pe(32'h81)); step();
    for (int i = 0; i < 4; i++) begin
      rd(3'd6);
      push($sformatf("p3_pulse_%0d", i), K_PUL, pe(pul3[i]));
      push($sformatf("p3_status_%0d", i), K_RD, pe(st3[i]));
      step();
    end

    // retrigger while busy extends the earlier bit
    wr(3'd3, 32'd5); step();
    wr(3'd2, 32'h01); push("rt_a", K_PUL, pe(32'h01)); step();
    push("rt_b", K_PUL, pe(32'h01)); step();
    wr(3'd2, 32'h02); push("rt_c", K_PUL, pe(32'h03)); step();
    for (int i = 0; i < 4; i++) begin
      push($sformatf("rt_hold_%0d", i), K_PUL, pe(32'h03)); step();
    end
    push("rt_end", K_PUL, 32'h0); step();

    // write on the expiry edge replaces the expiring bits
    wr(3'd3, 32'd4); step();
    wr(3'd2, 32'h01); push("ex_a", K_PUL, pe(32'h01)); step();
    for (int i = 0; i < 3; i++) begin
      push($sformatf("ex_old_%0d", i), K_PUL, pe(32'h01)); step();
    end
    wr(3'd2, 32'h10); push("ex_new", K_PUL, pe(32'h10)); step();
    for (int i = 0; i < 3; i++) begin
      push($sformatf("ex_hold_%0d", i), K_PUL, pe(32'h10)); step();
    end
    push("ex_end", K_PUL, 32'h0); step();

    // zero length behaves as one cycle
    wr(3'd3, 32'h0); step();
    wr(3'd2, 32'hFF); push("len0_on", K_PUL, pe(32'hFF)); step();
    push("len0_off", K_PUL, 32'h0); step();

    // long pulse, PULSE readback, W==0 reload, then asynchronous reset
    wr(3'd3, 32'd100); step();
    wr(3'd2, 32'h0F); push("long_on", K_PUL, pe(32'h0F)); step();
    rd(3'd2); step();
    push("rd_pulse", K_RD, pe(32'h0F)); step();
    wr(3'd2, 32'h0); push("w0_keep", K_PUL, pe(32'h0F)); step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_pulse_clr", 32'(pulse_out), 32'h0);
    chk("async_out_port", 32'(out_port), 32'hA5);
    chk("async_readdata", readdata, 32'h0);
    #2;
    reset_n = 1'b1;
    rd(3'd6); push("post_rst_status", K_RD, 32'h0); step();
    rd(3'd3); push("post_rst_len", K_RD, pe(32'd4)); step();

    // W==0 with nothing active still sets busy
    wr(3'd2, 32'h0); step();
    rd(3'd6); push("w0_idle_pulse", K_PUL, 32'h0); step();
    push("w0_idle_status", K_RD, pe(32'h0003_0001)); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/soc_system_hps_write_ctrl.md
Name: soc_system_hps_write_ctrl

Overview:
- Avalon-MM slave output PIO. The HPS writes it to drive control levels and timed strobes into FPGA fabric.
- It is the write-direction counterpart of the HPS read-status input PIO, and uses the same bus shape and the same registered-read timing.
- It provides a level output register with atomic set/clear aliases, plus a shared-timer pulse generator for one-shot strobes.

Parameters:
- DATA_WIDTH, 8, width of out_port and pulse_out (1..32).
- RESET_VALUE, 0, reset value of the DATA register / out_port.
- CNT_WIDTH, 16, width of the pulse-length register and the down-counter (1..32).
- PULSE_LEN_RESET, 4, reset value of PULSE_LEN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  DATA_WIDTH  level outputs.
- pulse_out  out  DATA_WIDTH  timed strobe outputs.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (reset_n). Reset values:
  - readdata = 0
  - out_port = RESET_VALUE
  - pulse_out = 0
  - PULSE_LEN = PULSE_LEN_RESET
  - counter = 0
- Write accept: a write is accepted when chipselect && !write_n. There is no waitrequest; every access completes in one cycle.
- Register map (unused readdata bits are 0):
  - 0 DATA, RW: writedata[DATA_WIDTH-1:0] loads out_port.
  - 1 reserved: reads 0, writes ignored.
  - 2 PULSE: W starts a pulse; R returns the active pulse_out bits.
  - 3 PULSE_LEN, RW: CNT_WIDTH bits.
  - 4 OUTSET, W: out_port |= writedata bits. Reads 0.
  - 5 OUTCLEAR, W: out_port &= ~writedata bits. Reads 0.
  - 6 STATUS, R: bit0 = busy (counter != 0); bits [CNT_WIDTH+15:16] = current counter value.
  - 7 reserved: reads 0, writes ignored.
- Read latency: readdata is registered every clock from the address mux, regardless of chipselect. Data therefore appears 1 cycle after address is presented.
- Output timing: out_port updates on the edge that accepts the write and is visible the next cycle.
- Pulse start: an accepted write of W to PULSE does the following on that edge:
  - pulse_out <= pulse_out | W[DATA_WIDTH-1:0]
  - counter <= max(PULSE_LEN, 1)
  - Any newly set bit is high for exactly max(PULSE_LEN, 1) cycles, starting the cycle after the write.
- Pulse countdown: while counter != 0, it decrements each cycle. On the edge where the counter goes 1 -> 0, pulse_out clears to 0.
- PULSE retrigger while busy: new bits are OR-ed into pulse_out and the counter reloads. Already-active bits are extended.
- Write on the expiry cycle (counter == 1 with a PULSE write on the same edge): pulse_out = W only, and the counter reloads. Expired bits do not stay asserted.
- PULSE write with W == 0: counter reloads, pulse_out is unchanged. If pulse_out was already 0, the counter still reloads and busy is set with no pulse visible.
- PULSE_LEN write while busy: takes effect at the next PULSE write only; the running count is unaffected.
- PULSE_LEN = 0: treated as 1 cycle.
- Unused writedata bits above DATA_WIDTH and above CNT_WIDTH are ignored.
- Reset asserted mid-pulse: counter and pulse_out clear immediately (asynchronously).

Optional Feature:
- Macro: SOC_SYSTEM_HPS_WRITE_CTRL_PULSE_EN
- Defined: the pulse generator, PULSE_LEN, and the STATUS counter field exist as specified above.
- Undefined:
  - No counter is built.
  - pulse_out is tied to 0.
  - Addresses 2, 3 and 6 read 0; writes to them are ignored.
  - DATA, OUTSET and OUTCLEAR are unchanged.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, pulse_out=0, readdata=0; read addr 3 -> 4.
- Write DATA=8'h3C, OUTSET=8'h01, OUTCLEAR=8'h0C -> out_port goes 3C, 3D, 31; read addr 0 -> 32'h31 one cycle after address.
- PULSE_LEN=3, write PULSE=8'h81 -> pulse_out=8'h81 for exactly 3 cycles, then 0; STATUS bit0 is high for the same 3 cycles; counter field reads 3, 2, 1.
- PULSE_LEN=5, write PULSE=8'h01, then PULSE=8'h02 two cycles later -> bit0 high 7 cycles total, bit1 high 5 cycles; both drop on the same edge.
- PULSE_LEN=4, write PULSE=8'h01, then PULSE=8'h10 exactly on the expiry edge -> pulse_out = 8'h10 for 4 cycles, with bit0 low from that edge.
- PULSE_LEN=0, write PULSE=8'hFF, then assert reset_n=0 during a pulse with PULSE_LEN=100 -> first case gives a 1-cycle 8'hFF pulse; the second clears pulse_out asynchronously and STATUS reads 0 after release.
